// File: rtl/shift_extend_unit.sv
// Immediate widener (sign/zero/upper-half) with an optional one-bit-per-cycle
// shifter for branch offsets, LUI and variable shifts, driven by start/done.
module shift_extend_unit #(
    parameter int IN_W    = 16,
    parameter int OUT_W   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [IN_W-1:0]    in,
    input  logic [2:0]         mode,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [OUT_W-1:0]   out
);

    localparam int CNT_W = $clog2(OUT_W + 1);

    localparam logic [2:0] M_SEXT = 3'd0;
    localparam logic [2:0] M_ZEXT = 3'd1;
    localparam logic [2:0] M_SLL  = 3'd2;
    localparam logic [2:0] M_SRL  = 3'd3;
    localparam logic [2:0] M_SRA  = 3'd4;
    localparam logic [2:0] M_LUI  = 3'd5;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [OUT_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       mode_q;

    logic [OUT_W-1:0] sext_val;
    logic [OUT_W-1:0] zext_val;
    logic [OUT_W-1:0] ext_val;
    logic [OUT_W-1:0] shift_val;
    logic [CNT_W-1:0] cnt_load;
    logic             is_shift;
    logic             accept;

    // start is a request accepted on any edge where the unit is IDLE or DONE
    // (busy low); done pulses for one cycle together with the new out value.
    assign accept = start && (state != SHIFT);

    always_comb begin
        sext_val = OUT_W'(signed'(in));
        zext_val = OUT_W'(in);
        ext_val  = '0;
        case (mode)
            M_SEXT, M_SLL, M_SRA: ext_val = sext_val;
            M_ZEXT, M_SRL:        ext_val = zext_val;
            M_LUI:                ext_val = zext_val << (OUT_W - IN_W);
            default:              ext_val = '0;
        endcase
    end

    // Shift counts beyond the width saturate; OUT_W single-bit steps already
    // produce the all-zero or all-sign result.
    always_comb begin
        is_shift = (mode == M_SLL) || (mode == M_SRL) || (mode == M_SRA);
        cnt_load = '0;
        if (is_shift) begin
            if (32'(shamt) >= 32'(OUT_W))
                cnt_load = CNT_W'(OUT_W);
            else
                cnt_load = CNT_W'(shamt);
        end
    end

    always_comb begin
        shift_val = acc;
        case (mode_q)
            M_SLL:   shift_val = acc << 1;
            M_SRL:   shift_val = acc >> 1;
            M_SRA:   shift_val = OUT_W'(signed'(acc) >>> 1);
            default: shift_val = acc;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            mode_q <= '0;
            out    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        acc    <= ext_val;
                        mode_q <= mode;
                        cnt    <= cnt_load;
                        if (cnt_load == '0) begin
                            state <= DONE;
                            out   <= ext_val;
                        end else begin
                            state <= SHIFT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    acc <= shift_val;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                        out   <= shift_val;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == SHIFT);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_extend_unit.sv
// Bench for shift_extend_unit: directed scenarios plus random operations,
// with expected results queued at drive time and popped at each done pulse.
module tb_shift_extend_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in;
  logic [2:0]  mode;
  logic [4:0]  shamt;
  logic        busy;
  logic        done;
  logic [31:0] out;

  int total;
  int bad;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  shift_extend_unit #(.IN_W(16), .OUT_W(32), .SHAMT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in(in), .mode(mode),
    .shamt(shamt), .busy(busy), .done(done), .out(out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ref_model(input logic [2:0] m, input logic [15:0] i,
                                            input logic [4:0] s);
    logic [31:0] sx;
    logic [31:0] zx;
    sx = {{16{i[15]}}, i};
    zx = {16'h0000, i};
    case (m)
      3'd0: return sx;
      3'd1: return zx;
      3'd2: return sx << s;
      3'd3: return zx >> s;
      3'd4: return 32'($signed(sx) >>> s);
      3'd5: return {i, 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  // Driver + monitor for one isolated operation; called at a negedge with the unit idle.
  task automatic do_op(input logic [2:0] m, input logic [15:0] i, input logic [4:0] s,
                       input string name);
    logic [31:0] e;
    int exp_lat;
    int lat;
    bit seen;
    exp_lat = (m >= 3'd2 && m <= 3'd4) ? int'(s) + 1 : 1;
    exp_q.push_back(ref_model(m, i, s));
    start = 1'b1; mode = m; in = i; shamt = s;
    @(posedge clk); #1;
    start = 1'b0; in = 16'($urandom); mode = 3'($urandom_range(0, 7)); shamt = 5'($urandom);
    lat = 1; seen = 0;
    while (!seen && lat <= 40) begin
      @(negedge clk);
      if (done) seen = 1;
      else begin
        total++;
        if (busy !== 1'b1 || out !== last_exp) begin
          bad++;
          $display("FAIL %s shifting: busy=%b out=%h required busy=1 out=%h", name, busy, out, last_exp);
        end
        @(posedge clk);
        lat++;
      end
    end
    e = exp_q.pop_front();
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s timeout: no done after %0d cycles, required latency %0d", name, lat, exp_lat);
    end else if (lat != exp_lat || out !== e || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s result: lat=%0d out=%h busy=%b required lat=%0d out=%h busy=0",
               name, lat, out, busy, exp_lat, e);
    end
    last_exp = e;
    @(posedge clk); @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || out !== e) begin
      bad++;
      $display("FAIL %s after: done=%b busy=%b out=%h required done=0 busy=0 out=%h", name, done, busy, out, e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in = '0; mode = '0; shamt = '0;
    repeat (2) @(negedge clk);
    total++;
    if (out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset: out=%h busy=%b done=%b required 0/0/0", out, busy, done);
    end
    rst_n = 1'b1;
    last_exp = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_extend();
    do_op(3'd0, 16'h8005, 5'd0, "sext");
    do_op(3'd1, 16'h8005, 5'd0, "zext");
    do_op(3'd5, 16'h1234, 5'd0, "lui");
    do_op(3'd7, 16'hBEEF, 5'd9, "reserved");
  endtask

  task automatic test_shift();
    do_op(3'd2, 16'h0005, 5'd2, "sll2");
    do_op(3'd2, 16'hFFFF, 5'd31, "sll31");
    do_op(3'd2, 16'h0123, 5'd0, "sll0");
    do_op(3'd4, 16'hF000, 5'd4, "sra4");
    do_op(3'd3, 16'hF000, 5'd4, "srl4");
    do_op(3'd4, 16'h8000, 5'd31, "sra31");
  endtask

  task automatic test_hold_start();
    logic [31:0] e;
    int lat;
    bit seen;
    exp_q.push_back(32'h0000_0028);
    start = 1'b1; mode = 3'd2; in = 16'h0005; shamt = 5'd3;
    @(posedge clk); #1;
    mode = 3'd1; in = 16'h7777; shamt = 5'd0;
    lat = 1; seen = 0;
    while (!seen && lat <= 20) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        start = 1'b0;
      end else begin
        @(posedge clk); #1;
        in = 16'($urandom);
        lat++;
      end
    end
    start = 1'b0;
    e = exp_q.pop_front();
    total++;
    if (!seen || lat != 4 || out !== e) begin
      bad++;
      $display("FAIL hold_start: seen=%0d lat=%0d out=%h required lat=4 out=%h", seen, lat, out, e);
    end
    last_exp = e;
    @(posedge clk); @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || out !== e) begin
      bad++;
      $display("FAIL hold_start after: done=%b busy=%b out=%h required 0/0/%h", done, busy, out, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    exp_q.push_back(ref_model(3'd0, 16'h8005, 5'd0));
    start = 1'b1; mode = 3'd0; in = 16'h8005; shamt = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (done !== 1'b1 || out !== e) begin
      bad++;
      $display("FAIL b2b first: done=%b out=%h required done=1 out=%h", done, out, e);
    end
    exp_q.push_back(32'h0000_00AA);
    start = 1'b1; mode = 3'd1; in = 16'h00AA; shamt = 5'd0;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    e = exp_q.pop_front();
    total++;
    if (done !== 1'b1 || out !== e) begin
      bad++;
      $display("FAIL b2b second: done=%b out=%h required done=1 out=%h", done, out, e);
    end
    last_exp = e;
    @(posedge clk); @(negedge clk);
    total++;
    if (done !== 1'b0 || out !== e) begin
      bad++;
      $display("FAIL b2b after: done=%b out=%h required done=0 out=%h", done, out, e);
    end
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    start = 1'b1; mode = 3'd4; in = 16'hF000; shamt = 5'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid pre: busy=%b required 1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid async: out=%h busy=%b done=%b required 0/0/0", out, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    total++;
    if (saw_done || out !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid no_done: saw_done=%0d out=%h required 0 and 0", saw_done, out);
    end
    last_exp = 32'h0;
    do_op(3'd0, 16'h8005, 5'd0, "sext_after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 16; k++) begin
      do_op(3'($urandom_range(0, 7)), 16'($urandom), 5'($urandom_range(0, 31)), "random");
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_extend();
    test_shift();
    test_hold_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d entries left, required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
